// File: rtl/pwm_sample_capture_if.sv
// ============================================================================
// Module   : pwm_sample_capture_if
// Brief    : Sample handshake bundle between pwm_sample_capture and its consumer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_sample_capture_if #(
  parameter int WIDTH = 11
);
  logic             sample_valid;
  logic             sample_ready;
  logic [WIDTH-1:0] sample_out;
  logic [WIDTH-1:0] period_len;
  logic             len_err;
  logic             overrun;

  modport master (
    output sample_valid, sample_out, period_len, len_err, overrun,
    input  sample_ready
  );

  modport slave (
    input  sample_valid, sample_out, period_len, len_err, overrun,
    output sample_ready
  );
endinterface

`default_nettype wire

// File: rtl/pwm_sample_capture.sv
// ============================================================================
// Module   : pwm_sample_capture
// Brief    : Recovers one high-time sample per PWM period from ampPWM/ampSD.
//            Optional macro PWM_CAP_SYNC_EN adds a 2-flop input synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_sample_capture #(
  parameter int               WIDTH  = 11,
  parameter logic [WIDTH-1:0] PERIOD = 11'd1042
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           ampPWM,
  input  wire logic           ampSD,
  pwm_sample_capture_if.master cap
);

  localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic pwm_in;
  logic sd_in;

`ifdef PWM_CAP_SYNC_EN
  logic [1:0] pwm_sync_q;
  logic [1:0] sd_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_sync_q <= 2'b00;
      sd_sync_q  <= 2'b00;
    end else begin
      pwm_sync_q <= {pwm_sync_q[0], ampPWM};
      sd_sync_q  <= {sd_sync_q[0], ampSD};
    end
  end

  assign pwm_in = pwm_sync_q[1];
  assign sd_in  = sd_sync_q[1];
`else
  assign pwm_in = ampPWM;
  assign sd_in  = ampSD;
`endif

  // The FSM works on the delayed stage p_q so that the registered rise lines up with it.
  logic p_in_q, p_q, rise_q;
  logic sd_in_q, sd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_in_q  <= 1'b0;
      p_q     <= 1'b0;
      rise_q  <= 1'b0;
      sd_in_q <= 1'b0;
      sd_q    <= 1'b0;
    end else begin
      p_in_q  <= pwm_in;
      p_q     <= p_in_q;
      rise_q  <= p_in_q & ~p_q;
      sd_in_q <= sd_in;
      sd_q    <= sd_in_q;
    end
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic             emit;
  logic [WIDTH-1:0] emit_pcnt;

  logic             sample_valid_q;
  logic [WIDTH-1:0] sample_out_q;
  logic [WIDTH-1:0] period_len_q;
  logic             len_err_q;
  logic             overrun_q;

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    hcnt_d    = hcnt_q;
    emit      = 1'b0;
    emit_pcnt = pcnt_q;
    if (!sd_q) begin
      state_d = IDLE;
      pcnt_d  = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_q) begin
            state_d = HIGH;
            pcnt_d  = C_ONE;
            hcnt_d  = C_ONE;
          end
        end
        HIGH, LOW: begin
          if (state_q == LOW && rise_q) begin
            emit      = 1'b1;
            emit_pcnt = pcnt_q;
            state_d   = HIGH;
            pcnt_d    = C_ONE;
            hcnt_d    = C_ONE;
          end else if (pcnt_q == PERIOD) begin
            // Timeout: the arriving cycle opens the next period at its current level.
            emit      = 1'b1;
            emit_pcnt = PERIOD;
            pcnt_d    = C_ONE;
            hcnt_d    = {{(WIDTH-1){1'b0}}, p_q};
            state_d   = p_q ? HIGH : LOW;
          end else begin
            pcnt_d = (pcnt_q == C_MAX) ? pcnt_q : pcnt_q + C_ONE;
            if (p_q) begin
              hcnt_d = (hcnt_q == C_MAX) ? hcnt_q : hcnt_q + C_ONE;
            end
            if (state_q == HIGH && !p_q) begin
              state_d = LOW;
            end
          end
        end
        default: begin
          state_d = IDLE;
          pcnt_d  = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pcnt_q         <= '0;
      hcnt_q         <= '0;
      sample_valid_q <= 1'b0;
      sample_out_q   <= '0;
      period_len_q   <= '0;
      len_err_q      <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
      if (emit) begin
        sample_valid_q <= 1'b1;
        sample_out_q   <= hcnt_q;
        period_len_q   <= emit_pcnt;
        len_err_q      <= (emit_pcnt != PERIOD);
        if (sample_valid_q && !cap.sample_ready) begin
          overrun_q <= 1'b1;
        end
      end else if (sample_valid_q && cap.sample_ready) begin
        sample_valid_q <= 1'b0;
      end
    end
  end

  assign cap.sample_valid = sample_valid_q;
  assign cap.sample_out   = sample_out_q;
  assign cap.period_len   = period_len_q;
  assign cap.len_err      = len_err_q;
  assign cap.overrun      = overrun_q;

endmodule

`default_nettype wire

// File: doc/pwm_sample_capture.md
# pwm_sample_capture

Measures the duty cycle of the amplifier PWM stream and recovers one sample per PWM period. The sound path drives `ampPWM`/`ampSD`; this block watches those same pins and turns each 96 kHz period back into a high-time count with a valid/ready handshake. It is used by the sound verification bench and by on-board loopback checks of the sound chain. It is synthesizable.

## Interface
- `WIDTH`, 11: counter and output width; must satisfy 2^WIDTH > `PERIOD`.
- `PERIOD`, 11'd1042: nominal PWM period in `clk` cycles (100 MHz / 1042 ≈ 96 kHz).

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ampPWM`  in  1  PWM stream under measurement.
- `ampSD`  in  1  amplifier enable; 0 = shutdown.
- `sample_ready`  in  1  consumer accepts the sample this cycle.
- `sample_valid`  out  1  sample registers hold an unconsumed sample.
- `sample_out`  out  WIDTH  high-time of the period, in cycles.
- `period_len`  out  WIDTH  length of the period, in cycles.
- `len_err`  out  1  `period_len != PERIOD`; valid with `sample_valid`.
- `overrun`  out  1  sticky; an unconsumed sample was overwritten.

## Operation
- `p` is the registered `ampPWM` (one flop; two more flops with the sync macro). `p_q` is `p` delayed by one cycle. A rise is `p & ~p_q`.
- Internal counters: `pcnt` counts cycles in the current period, including the current cycle. `hcnt` counts high cycles in the current period.
- States:
  - IDLE: counters are 0. On a rise: go to HIGH with `pcnt=1`, `hcnt=1`.
  - HIGH: each cycle, `pcnt++`. If `p=1`, `hcnt++`; if `p=0`, go to LOW.
  - LOW: each cycle, `pcnt++`. A rise terminates the period.
- Edge termination: only a rise seen in LOW terminates a period. The block emits (`hcnt`, `pcnt`). The rise cycle is the first cycle of the next period: `pcnt=1`, `hcnt=1`, go to HIGH.
- Timeout termination: in HIGH or LOW, a cycle arriving with `pcnt==PERIOD` and no terminating rise ends the period. The block emits (`hcnt`, `PERIOD`). The arriving cycle starts a new period: `pcnt=1`, `hcnt=p`, and the state follows `p`.
- Resulting behaviour for steady inputs:
  - Constant low gives sample 0 every `PERIOD` cycles.
  - Constant high gives sample `PERIOD` every `PERIOD` cycles.
- `ampSD=0` in any cycle forces IDLE and clears the counters. No sample is emitted for the partial period. Output registers and the handshake state are unaffected.
- Emit:
  - Loads `sample_out`, `period_len` and `len_err`, and sets `sample_valid=1`.
  - If `sample_valid & ~sample_ready` at the emit cycle, the old sample is overwritten and `overrun` is set.
  - Emit together with `sample_ready` loads the new sample, keeps `sample_valid=1`, and does not set `overrun`.
- Handshake:
  - `sample_valid & sample_ready` with no emit clears `sample_valid` next cycle.
  - Outputs are held stable while `sample_valid=1` and no emit occurs.
- Counters saturate at `2^WIDTH-1`. They cannot overflow when `PERIOD` fits.

## Timing
- Reset values: IDLE, counters 0, `sample_valid=0`, `sample_out=0`, `period_len=0`, `len_err=0`, `overrun=0`.
- Latency from the `ampPWM` rising edge that ends a period to `sample_valid` high: 3 cycles (input flop, edge detect, output register). Add 2 cycles with the sync macro.
- The first sample after reset or after `ampSD` rises requires a full period plus a rise, or a full period plus a timeout.
- `overrun` clears only on `rst`.

## Configuration
- `PWM_CAP_SYNC_EN`:
  - Defined: `ampPWM` and `ampSD` pass through a 2-flop synchronizer before the input flop. Use this for asynchronous board inputs. All latencies grow by 2 cycles.
  - Undefined: single input flop only. Use this for same-clock loopback in the bench.

## Test plan
- 1042-cycle period, 521 cycles high, repeated 4×, `sample_ready=1` → 3 samples with `sample_out=521`, `period_len=1042`, `len_err=0`. Each `sample_valid` occurs 3 cycles after the terminating rise.
- `ampPWM` held 0 for 3200 cycles after one rise at 100 high cycles → samples 100, then 0, 0, each with `period_len=1042`.
- `ampPWM` held 1 for 3200 cycles → samples of 1042 every 1042 cycles.
- 1000-cycle period, 300 high → `sample_out=300`, `period_len=1000`, `len_err=1`.
- `ampSD` dropped for 10 cycles mid-period, then the 521/1042 pattern resumes → no sample for the broken period, and the next correct sample follows.
- `sample_ready=0` across two emits → second sample replaces the first, `overrun=1`. Assert `sample_ready` → `sample_valid` clears next cycle and `overrun` stays 1 until `rst`.
